nn_layer_mac_seq: RTL and testbench

- Parametrised, time-multiplexed fully-connected neural-network layer for the forward pass.
- Computes out = act(sat(((W·x) + (b<<FRAC)) >>> FRAC)) over N_OUT×N_IN signed fixed-point weights, using one multiplier and one MAC per clock.
- Weights and biases are loaded through a write port. Input and output move through valid/ready and valid/ack handshakes.
- Sits between adjacent layer blocks in the network datapath and replaces the fixed 9×9 combinational layer.

---
 rtl/nn_layer_mac_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_nn_layer_mac_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_mac_seq.sv
// ---------------------------------------------------------------------------
// nn_layer_mac_seq
// Time-multiplexed fully-connected layer (forward pass). One signed
// weight*input product is accumulated per clock; each row finishes with a
// floor shift by FRAC, saturation to DW bits and an optional activation.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : input vector handshake (accepted in IDLE only)
//   act_mode        : 0/3 linear, 1 ReLU, 2 clamp[0,max]; sampled on accept
//   out_data/out_valid/out_ack : result handshake, data held after ack
//   sat_flag        : some row of the current result was clipped
//   wr_en/wr_row/wr_col/wr_data : weight/bias write port (wr_col==N_IN -> bias)
//   wr_err          : one-cycle pulse for a rejected write
//   busy            : block is not idle
// ---------------------------------------------------------------------------
module nn_layer_mac_seq #(
    parameter int N_IN  = 9,
    parameter int N_OUT = 9,
    parameter int DW    = 7,
    parameter int FRAC  = 6,
    localparam int ROW_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int COL_W = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*DW-1:0]    in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            act_mode,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  sat_flag,
    input  logic                  wr_en,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic [COL_W-1:0]      wr_col,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_err,
    output logic                  busy
);

    localparam int ACC_W = 2*DW + $clog2(N_IN + 1) + 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_IN - 1);
    localparam logic [COL_W-1:0] COL_BIAS = COL_W'(N_IN);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    // Saturation bounds, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                    state_r;
    logic [ROW_W-1:0]          row_r;
    logic [COL_W-1:0]          col_r;
    logic [N_IN*DW-1:0]        x_r;
    logic [1:0]                mode_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic                      out_valid_r;
    logic                      sat_flag_r;
    logic                      wr_err_r;
    logic signed [DW-1:0]      out_arr_r [0:N_OUT-1];
    logic signed [DW-1:0]      w_mem_r   [0:N_OUT-1][0:N_IN-1];
    logic signed [DW-1:0]      b_mem_r   [0:N_OUT-1];

    logic signed [DW-1:0]      x_arr_s   [0:N_IN-1];
    logic signed [DW-1:0]      w_cur_s;
    logic signed [DW-1:0]      x_cur_s;
    logic signed [DW-1:0]      b_cur_s;
    logic signed [2*DW-1:0]    prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   bias_ext_s;
    logic signed [ACC_W-1:0]   acc_base_s;
    logic signed [ACC_W-1:0]   sum_s;
    logic signed [ACC_W-1:0]   shifted_s;
    logic signed [DW-1:0]      clip_s;
    logic                      sat_row_s;
    logic signed [DW-1:0]      act_s;
    logic                      wr_ok_s;

    // Unpack the captured input vector and pack the result registers.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_xunpack
        assign x_arr_s[gi] = x_r[DW*gi +: DW];
    end
    for (genvar gr = 0; gr < N_OUT; gr++) begin : g_opack
        assign out_data[DW*gr +: DW] = out_arr_r[gr];
    end

    assign in_ready  = (state_r == ST_IDLE) && !reset;
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign sat_flag  = sat_flag_r;
    assign wr_err    = wr_err_r;

    // Write qualification: only in IDLE and only to an existing row/column.
    always_comb begin
        wr_ok_s = wr_en && (state_r == ST_IDLE) &&
                  (wr_row <= ROW_LAST) && (wr_col <= COL_BIAS);
    end

    // MAC datapath: product, bias preload at column 0, row finish arithmetic.
    always_comb begin
        w_cur_s    = w_mem_r[row_r][col_r];
        x_cur_s    = x_arr_s[col_r];
        b_cur_s    = b_mem_r[row_r];
        prod_s     = w_cur_s * x_cur_s;
        prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
        bias_ext_s = {{(ACC_W-DW){b_cur_s[DW-1]}}, b_cur_s} <<< FRAC;
        if (col_r == '0) begin
            acc_base_s = bias_ext_s;
        end else begin
            acc_base_s = acc_r;
        end
        sum_s     = acc_base_s + prod_ext_s;
        // Arithmetic shift gives floor rounding for negative sums.
        shifted_s = sum_s >>> FRAC;
        if (shifted_s > SAT_MAX) begin
            clip_s    = SAT_MAX[DW-1:0];
            sat_row_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            clip_s    = SAT_MIN[DW-1:0];
            sat_row_s = 1'b1;
        end else begin
            clip_s    = shifted_s[DW-1:0];
            sat_row_s = 1'b0;
        end
        // ReLU and clamp coincide: the upper bound is already the DW maximum.
        case (mode_r)
            2'd1, 2'd2: act_s = clip_s[DW-1] ? {DW{1'b0}} : clip_s;
            2'd0, 2'd3: act_s = clip_s;
            default:    act_s = clip_s;
        endcase
    end

    // Weight/bias storage and write-reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N_OUT; r++) begin
                b_mem_r[r] <= '0;
                for (int c = 0; c < N_IN; c++) begin
                    w_mem_r[r][c] <= '0;
                end
            end
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_ok_s;
            if (wr_ok_s) begin
                if (wr_col == COL_BIAS) begin
                    b_mem_r[wr_row] <= wr_data;
                end else begin
                    w_mem_r[wr_row][wr_col] <= wr_data;
                end
            end
        end
    end

    // Control FSM with accumulator, result registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            row_r       <= '0;
            col_r       <= '0;
            x_r         <= '0;
            mode_r      <= 2'd0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            sat_flag_r  <= 1'b0;
            for (int r = 0; r < N_OUT; r++) begin
                out_arr_r[r] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r        <= in_data;
                        mode_r     <= act_mode;
                        sat_flag_r <= 1'b0;
                        row_r      <= '0;
                        col_r      <= '0;
                        state_r    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_r <= sum_s;
                    if (col_r == COL_LAST) begin
                        out_arr_r[row_r] <= act_s;
                        sat_flag_r       <= sat_flag_r | sat_row_s;
                        col_r            <= '0;
                        if (row_r == ROW_LAST) begin
                            state_r     <= ST_OUT;
                            out_valid_r <= 1'b1;
                        end else begin
                            row_r <= row_r + ROW_ONE;
                        end
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                ST_OUT: begin
                    if (out_ack) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_mac_seq.sv
// Directed testbench for nn_layer_mac_seq with hand-computed expectations.
module tb_nn_layer_mac_seq;
    localparam int N_IN  = 9;
    localparam int N_OUT = 9;
    localparam int DW    = 7;
    localparam int LAT   = N_IN * N_OUT;

    logic                 clk;
    logic                 reset;
    logic [N_IN*DW-1:0]   in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           act_mode;
    logic [N_OUT*DW-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ack;
    logic                 sat_flag;
    logic                 wr_en;
    logic [3:0]           wr_row;
    logic [3:0]           wr_col;
    logic [DW-1:0]        wr_data;
    logic                 wr_err;
    logic                 busy;

    nn_layer_mac_seq dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .act_mode(act_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .sat_flag(sat_flag),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wr_err(wr_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int accept_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_OUT*DW-1:0] rep(input int v);
        logic [N_OUT*DW-1:0] r;
        for (int i = 0; i < N_OUT; i++) r[DW*i +: DW] = DW'(v);
        return r;
    endfunction

    // Parameter write; call at a falling edge, returns at a falling edge.
    task automatic wr_param(input int row, input int col, input int val, input logic exp_err);
        wr_en   = 1'b1;
        wr_row  = 4'(row);
        wr_col  = 4'(col);
        wr_data = DW'(val);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_err", {63'd0, wr_err}, {63'd0, exp_err});
    endtask

    task automatic start_vec(input logic [N_IN*DW-1:0] xv, input logic [1:0] mode);
        in_data  = xv;
        act_mode = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Wait for the result, check it, optionally hold off the ack, then ack.
    task automatic finish_vec(input string tag, input logic [N_OUT*DW-1:0] exp,
                              input logic exp_sat, input int hold);
        logic stable;
        for (int k = 0; k < 300 && out_valid !== 1'b1; k++) @(negedge clk);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_lat"}, 64'(cyc - accept_cyc), 64'(LAT));
        check({tag, "_data"}, {1'b0, out_data}, {1'b0, exp});
        check({tag, "_sat"}, {63'd0, sat_flag}, {63'd0, exp_sat});
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (h == 3) begin
                in_valid = 1'b1;
                in_data  = rep(1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_data !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || sat_flag !== exp_sat)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) check({tag, "_hold"}, {63'd0, stable}, 64'd1);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check({tag, "_drop"}, {62'd0, out_valid, busy}, 64'd0);
        check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    logic [N_OUT*DW-1:0] exp_v;

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; act_mode = 2'd0;
        out_ack = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_state", {59'd0, out_valid, sat_flag, wr_err, busy, in_ready}, 64'd1);
        check("rst_data", {1'b0, out_data}, 64'd0);
        @(negedge clk);

        // No weights written: every output is zero.
        start_vec(rep(20), 2'd0);
        check("mac_busy", {62'd0, busy, in_ready}, 64'd2);
        finish_vec("zero", rep(0), 1'b0, 0);

        // Diagonal 0.5 weights.
        for (int i = 0; i < N_OUT; i++) wr_param(i, i, 32, 1'b0);
        start_vec(rep(20), 2'd0);  finish_vec("diag_pos", rep(10), 1'b0, 0);
        start_vec(rep(-21), 2'd0); finish_vec("diag_floor", rep(-11), 1'b0, 0);
        start_vec(rep(-20), 2'd0); finish_vec("m0_neg", rep(-10), 1'b0, 0);
        start_vec(rep(-20), 2'd1); finish_vec("m1_neg", rep(0), 1'b0, 0);
        start_vec(rep(-20), 2'd2); finish_vec("m2_neg", rep(0), 1'b0, 0);
        start_vec(rep(20), 2'd2);  finish_vec("m2_pos", rep(10), 1'b0, 0);
        start_vec(rep(-20), 2'd3); finish_vec("m3_neg", rep(-10), 1'b0, 0);

        // Bias on row 3: (640 + 5*64) >> 6 = 15.
        wr_param(3, N_IN, 5, 1'b0);
        exp_v = rep(10);
        exp_v[DW*3 +: DW] = 7'd15;
        start_vec(rep(20), 2'd0);  finish_vec("bias3", exp_v, 1'b0, 0);

        // Stall the consumer for 10 cycles with a stray in_valid pulse.
        start_vec(rep(20), 2'd0);  finish_vec("hold", exp_v, 1'b0, 10);

        // Write during MAC is rejected and leaves weight[0][0] intact.
        start_vec(rep(20), 2'd0);
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_row = 4'd0; wr_col = 4'd0; wr_data = 7'h40;
        @(negedge clk);
        wr_en = 1'b0;
        check("mac_wr_err", {63'd0, wr_err}, 64'd1);
        @(negedge clk);
        check("mac_wr_err_end", {63'd0, wr_err}, 64'd0);
        finish_vec("mac_wr", exp_v, 1'b0, 0);
        start_vec(rep(20), 2'd0);  finish_vec("mac_wr_kept", exp_v, 1'b0, 0);

        // Out-of-range addresses are rejected.
        wr_param(9, 0, 63, 1'b1);
        wr_param(0, 10, 63, 1'b1);

        // Saturation with all weights 63.
        for (int r = 0; r < N_OUT; r++)
            for (int c = 0; c < N_IN; c++)
                wr_param(r, c, 63, 1'b0);
        start_vec(rep(63), 2'd0);  finish_vec("sat_hi", rep(63), 1'b1, 0);
        start_vec(rep(-64), 2'd0); finish_vec("sat_lo", rep(-64), 1'b1, 0);

        // Reset in the middle of a computation.
        start_vec(rep(63), 2'd0);
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", {61'd0, out_valid, busy, in_ready}, 64'd0);
        check("midrst_data", {1'b0, out_data}, 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        start_vec(rep(63), 2'd0);  finish_vec("after_rst", rep(0), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
